store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Posted-write buffer between the single-cycle core's store port and a slow data memory with a req/ack handshake. Stores retire from the core in one cycle into a FIFO while the block drains them to memory in order. Loads are held off (stall) until the buffer is empty, so a load never reads memory older than an outstanding store.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- st_valid  in  1  core presents a store this cycle (MemWrite)
- st_addr  in  AW  store address (ALUOut)
- st_data  in  DW  store data (RD2)
- ld_valid  in  1  core presents a load this cycle (MemRead)
- stall  out  1  combinational; core must hold PC and all state this cycle
- empty  out  1  buffer holds no entries and no write is in flight
- count  out  $clog2(DEPTH)+1  number of occupied entries
- mem_req  out  1  registered; write request to memory
- mem_addr  out  AW  registered; address of head entry, valid while mem_req=1
- mem_wdata  out  DW  registered; data of head entry, valid while mem_req=1
- mem_ack  in  1  single-cycle pulse from memory; write at head completed

## Operation
- Storage: DEPTH-entry circular FIFO of {addr, data}; write pointer wp, read pointer rp, count, all log2(DEPTH) bits except count; pointers wrap DEPTH-1 -> 0.
- Push: st_valid=1 and count<DEPTH (registered count) -> entry written at wp, wp+1.
- Pop: mem_ack=1 while in state REQ -> rp+1.
- Push and pop in the same cycle: both pointers advance, count unchanged.
- Full: count==DEPTH; a store is not accepted even if mem_ack pops in the same cycle; stall holds the store to the next cycle.
- stall = (st_valid & count==DEPTH) | (ld_valid & ~empty). st_valid and ld_valid together is illegal.
- empty = (count==0) & (state==IDLE).
- Drain FSM, two states:
  - IDLE: mem_req=0. If count>0 -> REQ; mem_addr/mem_wdata load head entry, mem_req<=1.
  - REQ: mem_req, mem_addr, mem_wdata held stable until mem_ack. On mem_ack: pop, mem_req<=0, -> IDLE.
- mem_ack in IDLE is ignored (no pop, no error).
- Ordering: memory sees writes in exact core program order; no coalescing, no forwarding.
- Address and data are passed unmodified; no alignment check.

## Timing
- Reset values: stall follows inputs (0 when st_valid=ld_valid=0), empty=1, count=0, mem_req=0, mem_addr=0, mem_wdata=0, state=IDLE, wp=rp=0. Storage contents undefined.
- Reset mid-transaction: outstanding and buffered stores are discarded; mem_req drops asynchronously; a late mem_ack after release is ignored (IDLE).
- Push latency: store on cycle N -> count increments at edge N+1.
- Issue latency: first push into empty buffer at edge N -> mem_req=1 from edge N+2 (count seen at N+1, FSM moves at N+2).
- Per-write cost: minimum 2 cycles (REQ with same-cycle ack, then one IDLE bubble); mem_req always low for at least one cycle between writes.
- Load stall releases the cycle after the final ack's edge (empty=1).

## Test plan
- Reset: drive reset=0 mid-run with count=3, mem_req=1 -> mem_req=0, count=0, empty=1 immediately; after release, pulsed mem_ack causes no change.
- Single store: st_addr=0x100, st_data=0xDEADBEEF at cycle 0, mem_ack pulsed 3 cycles after mem_req rises -> mem_addr/mem_wdata stable for all req cycles, count 1->0 after ack, empty=1.
- Fill to full: 5 back-to-back stores with mem_ack held 0, DEPTH=4 -> first 4 accepted, stall=1 on the 5th, count=4; ack once -> 5th accepted next cycle, count stays 4.
- Ordering and wrap: 10 stores (addr=4*i, data=i) with ack 1 cycle after each req -> memory receives data 0..9 in order, pointers wrap twice, no loss or duplication.
- Load hold: 2 stores then ld_valid=1 -> stall=1 until edge after second ack, then stall=0 with empty=1.
- Simultaneous push/pop: count=2, store coincident with mem_ack -> count stays 2, new entry issued third.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if
// Bundles the core-side store/load port and the memory-side req/ack write
// port of the store write buffer.
//   slave  : the buffer's view (takes st_*/ld_valid/mem_ack, drives the rest)
//   master : the environment's view (core plus memory)
// Handshake: the core's store is accepted on a rising edge where st_valid=1
// and stall=0; the core holds st_addr/st_data while stalled. The memory
// completes the write at the head with a one-cycle mem_ack pulse while
// mem_req=1; mem_addr/mem_wdata stay stable from mem_req rising until that
// acknowledging edge.
interface store_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          ld_valid;
  logic          stall;
  logic          empty;
  logic [CW-1:0] count;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, mem_ack,
    output stall, empty, count, mem_req, mem_addr, mem_wdata
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, mem_ack,
    input  stall, empty, count, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer
// Posted-write buffer between a single-cycle core's store port and a slow
// data memory. Stores retire into a DEPTH-entry circular FIFO in one cycle
// and are drained to memory strictly in program order, one req/ack write at
// a time. Loads stall until the buffer is empty and no write is in flight.
// Ports:
//   clk       : single clock, rising edge
//   reset     : asynchronous, active-low; clears all state
//   bus       : store_write_buffer_if.slave (core store/load port + memory
//               write port)
//   state_dbg : current drain FSM state (0 = IDLE, 1 = REQ)
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  store_write_buffer_if.slave   bus,
  output logic                  state_dbg
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t        state, state_nxt;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count_q;

  logic          full;
  logic          push;
  logic          pop;
  logic          load_head;
  logic          empty_int;

  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  // Full is judged on the registered count only: an ack in the same cycle
  // does not make room for a store until the next cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign push      = bus.st_valid & ~full;
  assign pop       = (state == REQ) & bus.mem_ack;
  assign empty_int = (count_q == '0) & (state == IDLE);

  // Drain FSM: next state and head-load strobe.
  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    case (state)
      IDLE: begin
        if (count_q != '0) begin
          state_nxt = REQ;
          load_head = 1'b1;
        end
      end
      REQ: begin
        if (bus.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pointers wrap naturally because DEPTH is a power of two. The in-flight
  // head stays counted until its ack, so empty covers the write in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wp] <= bus.st_addr;
      data_mem[wp] <= bus.st_data;
    end
  end

  // Memory-side registers: captured from the head when leaving IDLE, held
  // unchanged for the whole REQ phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (load_head) begin
      mem_req_q   <= 1'b1;
      mem_addr_q  <= addr_mem[rp];
      mem_wdata_q <= data_mem[rp];
    end else if (pop) begin
      mem_req_q   <= 1'b0;
    end
  end

  assign bus.stall     = (bus.st_valid & full) | (bus.ld_valid & ~empty_int);
  assign bus.empty     = empty_int;
  assign bus.count     = count_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq holds every accepted store not yet acknowledged (head may be in flight).
  logic [63:0] mq[$];
  logic [63:0] exp_q[$];
  logic [63:0] m_entry;
  bit          m_req;
  logic [DW-1:0] log_d[$];
  int          sz;
  bit          was;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_req = 1'b0;
      m_entry = '0;
    end else begin
      sz  = mq.size();
      was = m_req;
      if (was && bus.mem_ack) begin
        void'(mq.pop_front());
        m_req = 1'b0;
      end
      if (bus.st_valid && sz < DEPTH) begin
        mq.push_back({bus.st_addr, bus.st_data});
        exp_q.push_back({bus.st_addr, bus.st_data});
      end
      if (!was && sz > 0) begin
        m_req   = 1'b1;
        m_entry = mq[0];
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  bit m_empty;
  bit m_stall;
  logic [63:0] exp_w;
  always @(negedge clk) begin
    m_empty = (mq.size() == 0) && !m_req;
    m_stall = (bus.st_valid && mq.size() == DEPTH) || (bus.ld_valid && !m_empty);
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("empty", 64'(bus.empty), 64'(m_empty));
    chk("stall", 64'(bus.stall), 64'(m_stall));
    chk("mem_req", 64'(bus.mem_req), 64'(m_req));
    chk("state", 64'(state_dbg), 64'(m_req));
    if (m_req) chk("mem_bus", {bus.mem_addr, bus.mem_wdata}, m_entry);
    if (rst_n && bus.mem_req && bus.mem_ack) begin
      log_d.push_back(bus.mem_wdata);
      if (exp_q.size() == 0) chk("sb_unexpected_write", 64'd1, 64'd0);
      else begin
        exp_w = exp_q.pop_front();
        chk("sb_order", {bus.mem_addr, bus.mem_wdata}, exp_w);
      end
    end
  end

  // ---------------- driver ----------------
  logic [63:0] st_pend[$];
  bit ld_want   = 0;
  int ack_mode  = 0;  // 0 never, 1 after ack_delay req cycles, 2 random, 3 one-shot
  int ack_delay = 0;
  bit ack_once  = 0;
  int req_age   = 0;
  bit was_req   = 0;
  int ld_stalls = 0;

  // One clock cycle: drive at edge+1, note acceptance at the falling edge.
  task automatic cycle();
    if (st_pend.size() > 0) begin
      bus.st_valid = 1'b1;
      {bus.st_addr, bus.st_data} = st_pend[0];
    end else begin
      bus.st_valid = 1'b0;
    end
    bus.ld_valid = ld_want && (st_pend.size() == 0);
    case (ack_mode)
      1: bus.mem_ack = bus.mem_req && (req_age == ack_delay);
      2: bus.mem_ack = bus.mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      3: begin bus.mem_ack = ack_once; ack_once = 0; end
      default: bus.mem_ack = 1'b0;
    endcase
    @(negedge clk);
    if (bus.st_valid && !bus.stall) void'(st_pend.pop_front());
    if (bus.ld_valid && bus.stall) ld_stalls++;
    if (bus.ld_valid && !bus.stall) ld_want = 0;
    @(posedge clk);
    #1;
    req_age = bus.mem_req ? (was_req ? req_age + 1 : 0) : 0;
    was_req = bus.mem_req;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!(bus.empty && st_pend.size() == 0 && !ld_want) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(n >= budget), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_req", 64'(bus.mem_req), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single store, ack three cycles after mem_req rises.
    ack_mode = 1; ack_delay = 3; log_d.delete();
    st_pend.push_back({32'h100, 32'hDEADBEEF});
    cycle();
    chk("single_count1", 64'(bus.count), 64'd1);
    chk("single_noreq", 64'(bus.mem_req), 64'd0);
    cycle();
    chk("single_req", 64'(bus.mem_req), 64'd1);
    chk("single_addr", 64'(bus.mem_addr), 64'h100);
    chk("single_data", 64'(bus.mem_wdata), 64'hDEADBEEF);
    wait_empty(50);
    chk("single_count0", 64'(bus.count), 64'd0);
    chk("single_log", 64'(log_d.size() == 1 ? log_d[0] : 32'h0), 64'hDEADBEEF);

    // Fill to full with no acks, then one ack frees a slot.
    ack_mode = 0;
    for (int i = 0; i < 5; i++) st_pend.push_back({32'(32'h1000 + 4 * i), 32'(32'hF0 + i)});
    repeat (4) cycle();
    chk("fill_count4", 64'(bus.count), 64'd4);
    cycle();
    chk("fill_5th_held", 64'(st_pend.size()), 64'd1);
    chk("fill_stall", 64'(bus.stall), 64'd1);
    ack_mode = 3; ack_once = 1;
    cycle();
    chk("fill_ack_count3", 64'(bus.count), 64'd3);
    chk("fill_5th_still_held", 64'(st_pend.size()), 64'd1);
    cycle();
    chk("fill_count4_again", 64'(bus.count), 64'd4);
    chk("fill_5th_taken", 64'(st_pend.size()), 64'd0);
    ack_mode = 1; ack_delay = 0;
    wait_empty(100);

    // Ordering and pointer wrap: 10 stores, ack one cycle after each req.
    ack_mode = 1; ack_delay = 1; log_d.delete();
    for (int i = 0; i < 10; i++) st_pend.push_back({32'(4 * i), 32'(i)});
    wait_empty(300);
    chk("order_n", 64'(log_d.size()), 64'd10);
    for (int i = 0; i < 10 && i < log_d.size(); i++) chk("order_data", 64'(log_d[i]), 64'(i));

    // Load hold: two stores, then a load stalls until drained.
    ld_stalls = 0;
    st_pend.push_back({32'h300, 32'h11});
    st_pend.push_back({32'h304, 32'h22});
    ld_want = 1;
    wait_empty(100);
    chk("load_stall_cycles", 64'(ld_stalls), 64'd5);
    chk("load_empty", 64'(bus.empty), 64'd1);

    // Simultaneous push and pop at count 2.
    ack_mode = 0; log_d.delete();
    st_pend.push_back({32'h200, 32'hA1});
    st_pend.push_back({32'h204, 32'hA2});
    repeat (3) cycle();
    chk("pp_count2", 64'(bus.count), 64'd2);
    chk("pp_req", 64'(bus.mem_req), 64'd1);
    st_pend.push_back({32'h208, 32'hA3});
    ack_mode = 3; ack_once = 1;
    cycle();
    chk("pp_count_stays", 64'(bus.count), 64'd2);
    ack_mode = 1; ack_delay = 1;
    wait_empty(100);
    chk("pp_n", 64'(log_d.size()), 64'd3);
    chk("pp_third", 64'(log_d.size() == 3 ? log_d[2] : 32'h0), 64'hA3);

    // Reset mid-transaction with count=3 and mem_req=1.
    ack_mode = 0;
    for (int i = 0; i < 3; i++) st_pend.push_back({32'(32'h400 + 4 * i), 32'(32'hB0 + i)});
    repeat (4) cycle();
    chk("mr_count3", 64'(bus.count), 64'd3);
    chk("mr_req", 64'(bus.mem_req), 64'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    bus.st_valid = 1'b0; bus.ld_valid = 1'b0; bus.mem_ack = 1'b0;
    #1;
    chk("mr_req_drop", 64'(bus.mem_req), 64'd0);
    chk("mr_count0", 64'(bus.count), 64'd0);
    chk("mr_empty", 64'(bus.empty), 64'd1);
    @(posedge clk); @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ack_mode = 3; ack_once = 1;
    cycle();
    chk("mr_late_ack_count", 64'(bus.count), 64'd0);
    chk("mr_late_ack_req", 64'(bus.mem_req), 64'd0);
    chk("mr_late_ack_empty", 64'(bus.empty), 64'd1);

    // Randomized traffic against the model.
    ack_mode = 2;
    for (int n = 0; n < 800; n++) begin
      if (st_pend.size() == 0 && !ld_want) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: st_pend.push_back({32'($urandom), 32'($urandom)});
          6: ld_want = 1;
          default: ;
        endcase
      end
      cycle();
    end
    wait_empty(500);
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
